multicycle_controller: RTL and testbench

//  Moore-FSM control unit that sequences a multicycle MIPS datapath: one shared memory, IR, A/B and ALUOut regs.

---
 rtl/mc_pkg.sv | 132 +++++++++++++
 rtl/multicycle_controller_alu_decoder.sv | 27 ++
 rtl/multicycle_controller.sv | 93 +++++++++
 tb/tb_multicycle_controller.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic       instr_done;
    } ctrl_t;

    function automatic logic opcode_legal(logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

    // Moore control word for each state; everything not named stays 0.
    function automatic ctrl_t state_ctrl(state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.ir_write  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.pc_write  = 1'b1;
            end
            DECODE:  c.alu_src_b = SRCB_IMMSH;
            MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            MEMRD:   c.iord = 1'b1;
            MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            MEMWR: begin
                c.iord       = 1'b1;
                c.mem_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALUOP_FUNCT;
            end
            ALUWB: begin
                c.reg_dst    = 1'b1;
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a  = 1'b1;
                c.alu_op     = ALUOP_SUB;
                c.pc_src     = PCSRC_ALUOUT;
                c.branch     = 1'b1;
                c.instr_done = 1'b1;
            end
            ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            ADDIWB: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            JUMP: begin
                c.pc_src     = PCSRC_JUMP;
                c.pc_write   = 1'b1;
                c.instr_done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps the FSM's coarse ALU op plus the R-type funct field onto ALUControl.
module alu_decoder
    import mc_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_control_o
);

    // Fixed add/sub for address and branch math, funct lookup for R-type.
    always_comb begin
        alu_control_o = ALU_ADD;
        if (alu_op_i == ALUOP_SUB) begin
            alu_control_o = ALU_SUB;
        end else if (alu_op_i == ALUOP_FUNCT) begin
            case (funct_i)
                FN_ADD:  alu_control_o = ALU_ADD;
                FN_SUB:  alu_control_o = ALU_SUB;
                FN_AND:  alu_control_o = ALU_AND;
                FN_OR:   alu_control_o = ALU_OR;
                FN_SLT:  alu_control_o = ALU_SLT;
                default: alu_control_o = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle MIPS datapath. The control word is
// registered from the next state, so outputs change together with state_q.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int RESET_PC_WRITE = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] state_q,
    output logic       instr_done,
    output logic       illegal_op
);

    state_e fsm_q, fsm_d;
    ctrl_t  ctrl_q, fetch_ctrl;

    // Control word loaded on reset; FETCH already writes the PC, the
    // parameter only matters if FETCH ever stops doing so.
    always_comb begin
        fetch_ctrl = state_ctrl(FETCH);
        if (RESET_PC_WRITE != 0) fetch_ctrl.pc_write = 1'b1;
    end

    // Next-state selection; opcode is only consulted in DECODE and MEMADR.
    always_comb begin
        fsm_d = FETCH;
        case (fsm_q)
            FETCH: fsm_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: fsm_d = MEMADR;
                    OP_RTYPE:     fsm_d = EXECUTE;
                    OP_BEQ:       fsm_d = BRANCH;
                    OP_ADDI:      fsm_d = ADDIEX;
                    OP_J:         fsm_d = JUMP;
                    default:      fsm_d = FETCH;
                endcase
            end
            MEMADR:  fsm_d = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   fsm_d = MEMWB;
            EXECUTE: fsm_d = ALUWB;
            ADDIEX:  fsm_d = ADDIWB;
            default: fsm_d = FETCH;
        endcase
    end

    // State and registered control word; async reset lands in FETCH at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_q  <= FETCH;
            ctrl_q <= fetch_ctrl;
        end else begin
            fsm_q  <= fsm_d;
            ctrl_q <= state_ctrl(fsm_d);
        end
    end

    alu_decoder u_alu_decoder (
        .alu_op_i      (ctrl_q.alu_op),
        .funct_i       (funct),
        .alu_control_o (ALUControl)
    );

    assign pc_en      = ctrl_q.pc_write | (ctrl_q.branch & zero);
    assign IorD       = ctrl_q.iord;
    assign MemWrite   = ctrl_q.mem_write;
    assign IRWrite    = ctrl_q.ir_write;
    assign RegDst     = ctrl_q.reg_dst;
    assign MemtoReg   = ctrl_q.mem_to_reg;
    assign RegWrite   = ctrl_q.reg_write;
    assign ALUSrcA    = ctrl_q.alu_src_a;
    assign ALUSrcB    = ctrl_q.alu_src_b;
    assign PCSrc      = ctrl_q.pc_src;
    assign instr_done = ctrl_q.instr_done;
    assign state_q    = fsm_q;
    assign illegal_op = (fsm_q == DECODE) && !opcode_legal(opcode);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks lw, R-type, beq, sw,
// reset mid-instruction, illegal opcode and jump, checking each cycle.
module tb_multicycle_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_en, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
    logic       ALUSrcA, instr_done, illegal_op;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic [3:0] state_q;

    int errors = 0;
    int checks = 0;

    multicycle_controller dut (
        .clock      (clock),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .pc_en      (pc_en),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .ALUControl (ALUControl),
        .state_q    (state_q),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle past the edge before sampling.
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    initial begin
        reset  = 1'b1;
        opcode = 6'b000000;
        funct  = 6'b000000;
        zero   = 1'b0;

        // reset held 3 cycles
        repeat (3) @(posedge clock);
        #2;
        chk("rst_state", {4'd0, state_q}, 8'd0);
        chk("rst_irwrite", {7'd0, IRWrite}, 8'd1);
        chk("rst_pc_en", {7'd0, pc_en}, 8'd1);
        chk("rst_regwrite", {7'd0, RegWrite}, 8'd0);
        chk("rst_memwrite", {7'd0, MemWrite}, 8'd0);
        chk("rst_alusrcb", {6'd0, ALUSrcB}, 8'h01);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rel_state", {4'd0, state_q}, 8'd0);

        // lw: FETCH, DECODE, MEMADR, MEMRD, MEMWB
        opcode = 6'b100011;
        step();
        chk("lw_decode", {4'd0, state_q}, 8'd1);
        chk("lw_dec_srcb", {6'd0, ALUSrcB}, 8'h03);
        chk("lw_dec_illegal", {7'd0, illegal_op}, 8'd0);
        chk("lw_dec_regwrite", {7'd0, RegWrite}, 8'd0);
        step();
        chk("lw_memadr", {4'd0, state_q}, 8'd2);
        chk("lw_adr_srca", {7'd0, ALUSrcA}, 8'd1);
        chk("lw_adr_srcb", {6'd0, ALUSrcB}, 8'h02);
        chk("lw_adr_aluctl", {5'd0, ALUControl}, 8'h02);
        step();
        chk("lw_memrd", {4'd0, state_q}, 8'd3);
        chk("lw_rd_iord", {7'd0, IorD}, 8'd1);
        chk("lw_rd_regwrite", {7'd0, RegWrite}, 8'd0);
        chk("lw_rd_memtoreg", {7'd0, MemtoReg}, 8'd0);
        step();
        chk("lw_memwb", {4'd0, state_q}, 8'd4);
        chk("lw_wb_regwrite", {7'd0, RegWrite}, 8'd1);
        chk("lw_wb_memtoreg", {7'd0, MemtoReg}, 8'd1);
        chk("lw_wb_regdst", {7'd0, RegDst}, 8'd0);
        chk("lw_wb_done", {7'd0, instr_done}, 8'd1);
        step();
        chk("lw_back_fetch", {4'd0, state_q}, 8'd0);
        chk("lw_fetch_done", {7'd0, instr_done}, 8'd0);
        chk("lw_fetch_regwrite", {7'd0, RegWrite}, 8'd0);

        // R-type sub
        opcode = 6'b000000;
        funct  = 6'b100010;
        step();
        chk("r_decode", {4'd0, state_q}, 8'd1);
        step();
        chk("r_execute", {4'd0, state_q}, 8'd6);
        chk("r_ex_aluctl", {5'd0, ALUControl}, 8'h06);
        chk("r_ex_srca", {7'd0, ALUSrcA}, 8'd1);
        chk("r_ex_srcb", {6'd0, ALUSrcB}, 8'h00);
        funct = 6'b100101;
        #1;
        chk("r_ex_aluctl_or", {5'd0, ALUControl}, 8'h01);
        funct = 6'b111000;
        #1;
        chk("r_ex_aluctl_unk", {5'd0, ALUControl}, 8'h02);
        funct = 6'b100010;
        step();
        chk("r_aluwb", {4'd0, state_q}, 8'd7);
        chk("r_wb_regdst", {7'd0, RegDst}, 8'd1);
        chk("r_wb_regwrite", {7'd0, RegWrite}, 8'd1);
        chk("r_wb_memtoreg", {7'd0, MemtoReg}, 8'd0);
        chk("r_wb_done", {7'd0, instr_done}, 8'd1);
        step();
        chk("r_back_fetch", {4'd0, state_q}, 8'd0);

        // beq taken then not taken in the same BRANCH cycle
        opcode = 6'b000100;
        zero   = 1'b1;
        step();
        chk("beq_decode", {4'd0, state_q}, 8'd1);
        chk("beq_dec_pc_en", {7'd0, pc_en}, 8'd0);
        step();
        chk("beq_branch", {4'd0, state_q}, 8'd8);
        chk("beq_taken_pc_en", {7'd0, pc_en}, 8'd1);
        chk("beq_pcsrc", {6'd0, PCSrc}, 8'h01);
        chk("beq_aluctl", {5'd0, ALUControl}, 8'h06);
        chk("beq_done", {7'd0, instr_done}, 8'd1);
        zero = 1'b0;
        #1;
        chk("beq_nottaken_pc_en", {7'd0, pc_en}, 8'd0);
        step();
        chk("beq_back_fetch", {4'd0, state_q}, 8'd0);

        // sw: MemWrite exactly in MEMWR
        opcode = 6'b101011;
        step();
        chk("sw_dec_memwrite", {7'd0, MemWrite}, 8'd0);
        step();
        chk("sw_memadr", {4'd0, state_q}, 8'd2);
        chk("sw_adr_memwrite", {7'd0, MemWrite}, 8'd0);
        step();
        chk("sw_memwr", {4'd0, state_q}, 8'd5);
        chk("sw_wr_memwrite", {7'd0, MemWrite}, 8'd1);
        chk("sw_wr_iord", {7'd0, IorD}, 8'd1);
        chk("sw_wr_done", {7'd0, instr_done}, 8'd1);
        chk("sw_wr_regwrite", {7'd0, RegWrite}, 8'd0);
        step();
        chk("sw_back_fetch", {4'd0, state_q}, 8'd0);
        chk("sw_fetch_memwrite", {7'd0, MemWrite}, 8'd0);

        // sw again, reset asserted during MEMADR
        step();
        step();
        chk("swr_memadr", {4'd0, state_q}, 8'd2);
        reset = 1'b1;
        #1;
        chk("swr_async_state", {4'd0, state_q}, 8'd0);
        chk("swr_async_memwrite", {7'd0, MemWrite}, 8'd0);
        chk("swr_async_irwrite", {7'd0, IRWrite}, 8'd1);
        step();
        chk("swr_held_state", {4'd0, state_q}, 8'd0);
        chk("swr_held_memwrite", {7'd0, MemWrite}, 8'd0);
        @(negedge clock);
        reset = 1'b0;

        // illegal opcode then jump
        opcode = 6'b111111;
        step();
        chk("ill_decode", {4'd0, state_q}, 8'd1);
        chk("ill_pulse", {7'd0, illegal_op}, 8'd1);
        step();
        chk("ill_back_fetch", {4'd0, state_q}, 8'd0);
        chk("ill_pulse_gone", {7'd0, illegal_op}, 8'd0);
        chk("ill_regwrite", {7'd0, RegWrite}, 8'd0);
        chk("ill_memwrite", {7'd0, MemWrite}, 8'd0);
        opcode = 6'b000010;
        step();
        chk("j_decode", {4'd0, state_q}, 8'd1);
        chk("j_dec_illegal", {7'd0, illegal_op}, 8'd0);
        step();
        chk("j_jump", {4'd0, state_q}, 8'd11);
        chk("j_pcsrc", {6'd0, PCSrc}, 8'h02);
        chk("j_pc_en", {7'd0, pc_en}, 8'd1);
        chk("j_done", {7'd0, instr_done}, 8'd1);
        step();
        chk("j_back_fetch", {4'd0, state_q}, 8'd0);

        // addi: ADDIEX then ADDIWB writing rt from ALUOut
        opcode = 6'b001000;
        step();
        step();
        chk("addi_ex", {4'd0, state_q}, 8'd9);
        chk("addi_ex_srcb", {6'd0, ALUSrcB}, 8'h02);
        step();
        chk("addi_wb", {4'd0, state_q}, 8'd10);
        chk("addi_wb_regwrite", {7'd0, RegWrite}, 8'd1);
        chk("addi_wb_regdst", {7'd0, RegDst}, 8'd0);
        step();
        chk("addi_back_fetch", {4'd0, state_q}, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
